ring_osc_meas_ctrl: RTL

Measurement sequencer for the 16-stage ring oscillator used as DCO/TDC core.
- On request, enables the ring, waits a settle interval, then snapshots ring phase (16 taps) and the osc-domain coarse period counter (Gray) at the start and end of a programmable window of clk cycles.
- Outputs the elapsed ring phase steps, in units of one inverter delay. This count drives ring frequency calibration and the DCO period-tuning loop.
- Sits between the ring oscillator model and the calibration FSM.

---
 rtl/tdc_pkg.sv | 25 ++
 rtl/ring_phase_dec.sv | 23 ++
 rtl/ring_osc_meas_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types, constants and helpers for the ring-oscillator measurement / TDC path.
package tdc_pkg;

    localparam int unsigned                   RING_STAGES   = 16;
    localparam int unsigned                   PHASE_W       = 5;
    localparam logic [RING_STAGES-1:0]        RING_ALT_MASK = 16'hAAAA;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WINDOW,
        DONE
    } meas_state_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int unsigned s = 1; s < 32; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/ring_phase_dec.sv
// Ring tap decoder: 16 alternating-polarity taps to a 0..31 phase index.
module ring_phase_dec
    import tdc_pkg::*;
(
    input  logic [RING_STAGES-1:0] inv_out,
    output logic [PHASE_W-1:0]     phase
);

    logic [RING_STAGES-1:0] x;
    logic [PHASE_W-1:0]     ones;

    // Undo the alternating inversion, popcount (bubble tolerant), fold second half-period.
    always_comb begin
        x    = inv_out ^ RING_ALT_MASK;
        ones = '0;
        for (int unsigned i = 0; i < RING_STAGES; i++) begin
            ones = ones + PHASE_W'(x[i]);
        end
        // 32 - ones, taken modulo 2^PHASE_W (ones==16 maps to 16)
        phase = x[RING_STAGES-1] ? (PHASE_W'(0) - ones) : ones;
    end

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Ring oscillator measurement sequencer: enable, settle, snapshot window, report phase steps.
module ring_osc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int unsigned COARSE_W   = 12,
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIN_W-1:0]            win_cycles,
    input  logic                        osc_hold,
    input  logic [RING_STAGES-1:0]      inv_out,
    input  logic [COARSE_W-1:0]         osc_cyc_gray,
    output logic                        osc_en,
    output logic                        busy,
    output logic                        done,
    output logic [COARSE_W+PHASE_W-1:0] result
);

    localparam int unsigned SNAP_W = COARSE_W + PHASE_W;

    meas_state_t       state_q,  state_d;
    logic [WIN_W-1:0]  cnt_q,    cnt_d;
    logic [WIN_W-1:0]  win_q,    win_d;
    logic [SNAP_W-1:0] snap0_q,  snap0_d;
    logic [SNAP_W-1:0] snap1_q,  snap1_d;
    logic [SNAP_W-1:0] result_q, result_d;
    logic              osc_en_q, osc_en_d;

    logic [PHASE_W-1:0] phase;
    logic [SNAP_W-1:0]  live_snap;

    ring_phase_dec u_phase_dec (
        .inv_out (inv_out),
        .phase   (phase)
    );

    assign live_snap = {COARSE_W'(gray2bin(32'(osc_cyc_gray))), phase};

    // State and datapath registers; reset aborts and drops osc_en immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            snap0_q  <= '0;
            snap1_q  <= '0;
            result_q <= '0;
            osc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            snap0_q  <= snap0_d;
            snap1_q  <= snap1_d;
            result_q <= result_d;
            osc_en_q <= osc_en_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        snap0_d  = snap0_q;
        snap1_d  = snap1_q;
        result_d = result_q;
        osc_en_d = osc_en_q;
        unique case (state_q)
            IDLE: begin
                osc_en_d = osc_hold;
                if (start) begin
                    state_d  = SETTLE;
                    osc_en_d = 1'b1;
                    win_d    = (win_cycles == '0) ? WIN_W'(1) : win_cycles;
                    cnt_d    = WIN_W'(SETTLE_CYC);
                end
            end
            SETTLE: begin
                osc_en_d = 1'b1;
                if (cnt_q == WIN_W'(1)) begin
                    snap0_d = live_snap;
                    cnt_d   = win_q;
                    state_d = WINDOW;
                end else begin
                    cnt_d = cnt_q - WIN_W'(1);
                end
            end
            WINDOW: begin
                // snap1 is taken as the count reaches zero; the following edge
                // (count already zero) enters DONE and registers the difference.
                osc_en_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = snap1_q - snap0_q;
                end else begin
                    cnt_d = cnt_q - WIN_W'(1);
                    if (cnt_q == WIN_W'(1)) begin
                        snap1_d = live_snap;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                osc_en_d = osc_hold;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        osc_en = osc_en_q;
        result = result_q;
    end

endmodule
